// File: rtl/line_draw_engine.sv
// Bresenham line rasteriser that feeds pixels to the 160x120 VGA adapter, one per clock.
// Define LINE_CLIP_EN to suppress plot for points outside the visible screen.
module line_draw_engine #(
    parameter int XW            = 8,
    parameter int YW            = 7,
    parameter int SCREEN_WIDTH  = 160,
    parameter int SCREEN_HEIGHT = 120
) (
    input  logic          clk,
    input  logic          resetb,
    input  logic          start,
    input  logic [XW-1:0] x0,
    input  logic [YW-1:0] y0,
    input  logic [XW-1:0] x1,
    input  logic [YW-1:0] y1,
    input  logic [2:0]    colour_in,
    output logic [XW-1:0] x,
    output logic [YW-1:0] y,
    output logic [2:0]    colour,
    output logic          plot,
    output logic          busy,
    output logic          done
);

    localparam int EW = XW + 3;
    localparam logic [XW:0] SW_L = (XW+1)'(SCREEN_WIDTH);
    localparam logic [YW:0] SH_L = (YW+1)'(SCREEN_HEIGHT);
`ifdef LINE_CLIP_EN
    localparam logic CLIP_EN = 1'b1;
`else
    localparam logic CLIP_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_INIT = 2'd1,
        S_DRAW = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t state_r, state_s;

    logic [XW-1:0]        x0_r, x1_r, cx_r, x_r;
    logic [XW-1:0]        x0_s, x1_s, cx_s, x_s;
    logic [YW-1:0]        y0_r, y1_r, cy_r, y_r;
    logic [YW-1:0]        y0_s, y1_s, cy_s, y_s;
    logic [2:0]           col_r, col_s, colour_r, colour_s;
    logic                 sx_r, sx_s, sy_r, sy_s;
    logic                 plot_r, plot_s, busy_r, busy_s, done_r, done_s;
    logic signed [EW-1:0] dx_r, dx_s, dy_r, dy_s, err_r, err_s;
    logic signed [EW-1:0] ddx_s, ddy_s, adx_s, ndy_s, e2_s;
    logic                 at_end_s, on_screen_s;

    // Endpoint differences and Bresenham helpers derived from the latched request and current error.
    always_comb begin
        ddx_s       = $signed({{(EW-XW){1'b0}}, x1_r}) - $signed({{(EW-XW){1'b0}}, x0_r});
        ddy_s       = $signed({{(EW-YW){1'b0}}, y1_r}) - $signed({{(EW-YW){1'b0}}, y0_r});
        adx_s       = ddx_s[EW-1] ? -ddx_s : ddx_s;
        ndy_s       = ddy_s[EW-1] ? ddy_s : -ddy_s;
        e2_s        = err_r <<< 1;
        at_end_s    = (cx_r == x1_r) && (cy_r == y1_r);
        on_screen_s = ({1'b0, cx_r} < SW_L) && ({1'b0, cy_r} < SH_L);
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!resetb) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state, datapath and output computation; holds everything by default.
    always_comb begin
        state_s  = state_r;
        x0_s     = x0_r;
        y0_s     = y0_r;
        x1_s     = x1_r;
        y1_s     = y1_r;
        col_s    = col_r;
        cx_s     = cx_r;
        cy_s     = cy_r;
        sx_s     = sx_r;
        sy_s     = sy_r;
        dx_s     = dx_r;
        dy_s     = dy_r;
        err_s    = err_r;
        x_s      = x_r;
        y_s      = y_r;
        colour_s = colour_r;
        plot_s   = 1'b0;
        done_s   = 1'b0;
        busy_s   = (state_r != S_IDLE);
        case (state_r)
            S_IDLE: begin
                if (start) begin
                    x0_s    = x0;
                    y0_s    = y0;
                    x1_s    = x1;
                    y1_s    = y1;
                    col_s   = colour_in;
                    state_s = S_INIT;
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_INIT: begin
                dx_s    = adx_s;
                dy_s    = ndy_s;
                err_s   = adx_s + ndy_s;
                sx_s    = (x0_r < x1_r);
                sy_s    = (y0_r < y1_r);
                cx_s    = x0_r;
                cy_s    = y0_r;
                state_s = S_DRAW;
            end
            S_DRAW: begin
                x_s      = cx_r;
                y_s      = cy_r;
                colour_s = col_r;
                plot_s   = on_screen_s | ~CLIP_EN;
                if (at_end_s) begin
                    state_s = S_DONE;
                end else begin
                    state_s = S_DRAW;
                    // Both axis decisions use the error value from before this step.
                    if (e2_s >= dy_r) begin
                        err_s = err_s + dy_r;
                        cx_s  = sx_r ? cx_r + XW'(1'b1) : cx_r - XW'(1'b1);
                    end else begin
                        cx_s  = cx_r;
                    end
                    if (e2_s <= dx_r) begin
                        err_s = err_s + dx_r;
                        cy_s  = sy_r ? cy_r + YW'(1'b1) : cy_r - YW'(1'b1);
                    end else begin
                        cy_s  = cy_r;
                    end
                end
            end
            S_DONE: begin
                done_s  = 1'b1;
                state_s = S_IDLE;
            end
            default: begin
                state_s = S_IDLE;
            end
        endcase
    end

    // Datapath and registered output stage.
    always_ff @(posedge clk) begin
        if (!resetb) begin
            x0_r     <= '0;
            y0_r     <= '0;
            x1_r     <= '0;
            y1_r     <= '0;
            col_r    <= 3'b000;
            cx_r     <= '0;
            cy_r     <= '0;
            sx_r     <= 1'b0;
            sy_r     <= 1'b0;
            dx_r     <= '0;
            dy_r     <= '0;
            err_r    <= '0;
            x_r      <= '0;
            y_r      <= '0;
            colour_r <= 3'b000;
            plot_r   <= 1'b0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
        end else begin
            x0_r     <= x0_s;
            y0_r     <= y0_s;
            x1_r     <= x1_s;
            y1_r     <= y1_s;
            col_r    <= col_s;
            cx_r     <= cx_s;
            cy_r     <= cy_s;
            sx_r     <= sx_s;
            sy_r     <= sy_s;
            dx_r     <= dx_s;
            dy_r     <= dy_s;
            err_r    <= err_s;
            x_r      <= x_s;
            y_r      <= y_s;
            colour_r <= colour_s;
            plot_r   <= plot_s;
            busy_r   <= busy_s;
            done_r   <= done_s;
        end
    end

    assign x      = x_r;
    assign y      = y_r;
    assign colour = colour_r;
    assign plot   = plot_r;
    assign busy   = busy_r;
    assign done   = done_r;

endmodule

// File: tb/tb_line_draw_engine.sv
// Self-checking bench for line_draw_engine: directed cases plus random lines against an integer Bresenham model.
module tb_line_draw_engine;

    localparam int XW = 8;
    localparam int YW = 7;

    logic          clk = 1'b0;
    logic          resetb = 1'b0;
    logic          start = 1'b0;
    logic [XW-1:0] x0 = '0, x1 = '0;
    logic [YW-1:0] y0 = '0, y1 = '0;
    logic [2:0]    colour_in = 3'b000;
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic [2:0]    colour;
    logic          plot, busy, done;

    int tests = 0;
    int fails = 0;
    int exp_x[$];
    int exp_y[$];

    line_draw_engine #(.XW(XW), .YW(YW), .SCREEN_WIDTH(160), .SCREEN_HEIGHT(120)) dut (
        .clk(clk), .resetb(resetb), .start(start),
        .x0(x0), .y0(y0), .x1(x1), .y1(y1), .colour_in(colour_in),
        .x(x), .y(y), .colour(colour), .plot(plot), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    // Integer reference: the list of points a Bresenham walk visits from (ax0,ay0) to (ax1,ay1).
    task automatic model(input int ax0, input int ay0, input int ax1, input int ay1);
        int dx, dy, sx, sy, err, e2, cx, cy;
        exp_x.delete();
        exp_y.delete();
        dx  = (ax1 > ax0) ? ax1 - ax0 : ax0 - ax1;
        dy  = (ay1 > ay0) ? ay0 - ay1 : ay1 - ay0;
        sx  = (ax0 < ax1) ? 1 : -1;
        sy  = (ay0 < ay1) ? 1 : -1;
        err = dx + dy;
        cx  = ax0;
        cy  = ay0;
        for (int k = 0; k < 1000; k++) begin
            exp_x.push_back(cx);
            exp_y.push_back(cy);
            if (cx == ax1 && cy == ay1) break;
            e2 = 2 * err;
            if (e2 >= dy) begin err += dy; cx += sx; end
            if (e2 <= dx) begin err += dx; cy += sy; end
        end
    endtask

    function automatic logic exp_plot(input int px, input int py);
`ifdef LINE_CLIP_EN
        return (px < 160) && (py < 120);
`else
        return 1'b1;
`endif
    endfunction

    // Runs one line from a posedge+1 phase; poke pulses start again during DRAW.
    task automatic draw_check(input int ax0, input int ay0, input int ax1, input int ay1,
                              input int col, input bit poke);
        int n;
        model(ax0, ay0, ax1, ay1);
        n = exp_x.size();
        x0 = XW'(ax0); y0 = YW'(ay0); x1 = XW'(ax1); y1 = YW'(ay1);
        colour_in = 3'(col);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        x0 = XW'($urandom); y0 = YW'($urandom); x1 = XW'($urandom); y1 = YW'($urandom);
        colour_in = 3'($urandom);
        check("accept_plot", 32'(plot), 32'd0);
        @(posedge clk); #1;
        check("init_plot", 32'(plot), 32'd0);
        check("init_busy", 32'(busy), 32'd1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            start = 1'b0;
            check("pix_x", 32'(x), 32'(exp_x[i]));
            check("pix_y", 32'(y), 32'(exp_y[i]));
            check("pix_colour", 32'(colour), 32'(col));
            check("pix_plot", 32'(plot), 32'(exp_plot(exp_x[i], exp_y[i])));
            check("pix_done", 32'(done), 32'd0);
            if (poke && i == 1) start = 1'b1;
        end
        @(posedge clk); #1;
        check("done_pulse", 32'(done), 32'd1);
        check("done_plot", 32'(plot), 32'd0);
        check("hold_x", 32'(x), 32'(exp_x[n-1]));
        check("hold_y", 32'(y), 32'(exp_y[n-1]));
        @(posedge clk); #1;
        check("done_once", 32'(done), 32'd0);
        check("idle_busy", 32'(busy), 32'd0);
        check("idle_plot", 32'(plot), 32'd0);
        if (poke) begin
            repeat (3) begin
                @(posedge clk); #1;
                check("poke_ignored_busy", 32'(busy), 32'd0);
                check("poke_ignored_done", 32'(done), 32'd0);
            end
        end
    endtask

    initial begin
        int rx0, ry0, rx1, ry1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_x", 32'(x), 32'd0);
        check("rst_y", 32'(y), 32'd0);
        check("rst_colour", 32'(colour), 32'd0);
        check("rst_plot", 32'(plot), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        resetb = 1'b1;
        @(posedge clk); #1;

        draw_check(0, 0, 4, 0, 4, 1'b0);
        draw_check(10, 20, 10, 17, 2, 1'b0);
        draw_check(0, 0, 2, 5, 7, 1'b0);
        draw_check(7, 7, 7, 7, 1, 1'b0);
        draw_check(0, 0, 200, 50, 5, 1'b1);
        draw_check(157, 0, 161, 0, 6, 1'b0);

        // Reset during the third pixel of a long horizontal line.
        x0 = '0; y0 = '0; x1 = XW'(100); y1 = '0; colour_in = 3'b011;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) begin @(posedge clk); #1; end
        check("pre_rst_x", 32'(x), 32'd2);
        check("pre_rst_plot", 32'(plot), 32'd1);
        resetb = 1'b0;
        @(posedge clk); #1;
        check("mid_rst_plot", 32'(plot), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_x", 32'(x), 32'd0);
        check("mid_rst_y", 32'(y), 32'd0);
        resetb = 1'b1;
        @(posedge clk); #1;
        check("post_rst_plot", 32'(plot), 32'd0);
        draw_check(33, 90, 40, 85, 3, 1'b0);

        for (int t = 0; t < 20; t++) begin
            rx0 = $urandom_range(255, 0);
            ry0 = $urandom_range(127, 0);
            rx1 = $urandom_range(255, 0);
            ry1 = $urandom_range(127, 0);
            draw_check(rx0, ry0, rx1, ry1, $urandom_range(7, 0), t[0]);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
